fetch_load_ctrl: RTL and testbench
==================================

# fetch_load_ctrl

Sequencing controller for the instruction-fetch stage. Takes command and data bytes from the UART receiver and assembles program words. It writes them into instruction memory through the fetch stage's load port (instruction, address, loading). It then gates the pipeline clock-enable for continuous run or single-step execution until the fetch stage raises its halt signal.

## Interface
Parameters:
- DATA_WIDTH, 32, instruction/address width
- ADDR_STEP, 4, address increment per loaded word
- MEM_DEPTH, 256, words in instruction memory; max load count

Ports:
- i_clock  in  1  single system clock; all logic on rising edge
- i_reset  in  1  asynchronous, active-low reset
- i_rx_data  in  8  received byte
- i_rx_valid  in  1  one-cycle strobe, i_rx_data valid
- i_halt  in  1  halt signal from fetch stage (level)
- o_instruccion  out  DATA_WIDTH  word to instruction memory
- o_address  out  DATA_WIDTH  write address to instruction memory
- o_loading  out  1  high for whole load sequence
- o_wr_en  out  1  one-cycle write strobe, o_instruccion/o_address valid
- o_pipe_enable  out  1  pipeline/PC advance enable
- o_pipe_flush  out  1  one-cycle pipeline reset request
- o_busy  out  1  high in any state except IDLE and HALTED
- o_halted  out  1  high in HALTED
- o_cycle_count  out  32  enabled cycles since last load/clear

## Operation
- Commands are accepted only in IDLE unless stated: 'L'=0x4C load, 'R'=0x52 run, 'S'=0x53 step, 'C'=0x43 clear. Other bytes are ignored.
- States: IDLE, LD_COUNT, LD_BYTE, LD_WRITE, RUN, STEP, HALTED.
- IDLE, 'L': go to LD_COUNT and assert o_loading. Clear o_cycle_count and the word address.
- LD_COUNT: the next byte is N words; N=0 means 256. N is clamped to MEM_DEPTH. Go to LD_BYTE.
- LD_BYTE: collect 4 bytes, MSB first, into the shift register. After the 4th byte, go to LD_WRITE.
- LD_WRITE (one cycle): pulse o_wr_en with the assembled word and current address. Then add ADDR_STEP to the address (wraps mod 2^DATA_WIDTH) and decrement the remaining-word count.
  - If remaining is 0: pulse o_pipe_flush, drop o_loading, go to IDLE.
  - Otherwise: go to LD_BYTE.
- The first word goes to address 0. While o_loading is high, o_pipe_enable is 0 and o_rx_valid bytes are data only, never commands.
- IDLE, 'R': go to RUN. o_pipe_enable=1 every cycle; o_cycle_count += 1 per enabled cycle.
  - i_halt sampled high: go to HALTED; enable drops the next cycle.
  - Byte 'P'=0x50 received: go to IDLE (pause). Other bytes are ignored.
- IDLE, 'S': go to STEP. Exactly one cycle of o_pipe_enable=1 and count += 1, then go to IDLE, or to HALTED if i_halt is high in that cycle.
- HALTED: o_halted=1, o_pipe_enable=0.
  - 'C': pulse o_pipe_flush, go to IDLE, clear count.
  - 'L': start a load as in IDLE.
  - 'R' and 'S' are ignored.
- o_cycle_count saturates at 0xFFFFFFFF.
- i_halt is ignored outside RUN and STEP.

## Timing
- Reset (async assert, synchronous release): state IDLE. All outputs are 0, including data, address, count, and strobes.
- A byte strobe is consumed on the edge it is sampled; state changes on that edge.
- The o_wr_en pulse occurs exactly 1 cycle after the edge that accepts the 4th byte of a word.
- o_pipe_flush is a single cycle, coincident with the return to IDLE.
- o_pipe_enable is registered: asserted the cycle after the 'R'/'S' byte is accepted.
- Halt latency: with i_halt high at edge k in RUN, o_pipe_enable is 0 from edge k onward.
- Back-to-back bytes, one per cycle, must be accepted in LD_BYTE.
- A byte arriving in the LD_WRITE cycle is held and consumed as the first byte of the next word; it is not lost.
- Reset mid-load: the load is aborted, o_loading drops immediately, and memory contents are unspecified.

## Test plan
- Reset mid-RUN → all outputs 0 asynchronously, state IDLE, count 0.
- Send 'L',0x02,DE AD BE EF,00 00 00 13 → o_wr_en twice with (0xDEADBEEF, addr 0) and (0x00000013, addr 4). Then one o_pipe_flush, and o_loading drops.
- 'L',0x00 plus 1024 bytes → 256 writes, last address 0x3FC; o_loading is high for the whole sequence.
- 'R', i_halt raised after 10 cycles → o_cycle_count=10, o_halted=1. A following 'R' is ignored, and 'C' returns to IDLE with count 0.
- Three 'S' bytes spaced 5 cycles apart → exactly 3 single-cycle o_pipe_enable pulses, count=3.
- 'R' then 'P' after 7 cycles → IDLE, enable low, count=7. A 0x52 sent as load data is written as data and does not start RUN.

Source files
------------

// File: rtl/fetch_load_ctrl.sv
// Instruction-fetch sequencer: builds program words from UART bytes, writes them
// to instruction memory, then gates the pipeline enable for run or single-step.
module fetch_load_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_STEP  = 4,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [7:0]            i_rx_data,
    input  logic                  i_rx_valid,
    input  logic                  i_halt,
    output logic [DATA_WIDTH-1:0] o_instruccion,
    output logic [DATA_WIDTH-1:0] o_address,
    output logic                  o_loading,
    output logic                  o_wr_en,
    output logic                  o_pipe_enable,
    output logic                  o_pipe_flush,
    output logic                  o_busy,
    output logic                  o_halted,
    output logic [31:0]           o_cycle_count
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LD_COUNT = 3'd1;
    localparam logic [2:0] S_LD_BYTE  = 3'd2;
    localparam logic [2:0] S_LD_WRITE = 3'd3;
    localparam logic [2:0] S_RUN      = 3'd4;
    localparam logic [2:0] S_STEP     = 3'd5;
    localparam logic [2:0] S_HALTED   = 3'd6;

    localparam logic [7:0] CMD_LOAD  = 8'h4C;
    localparam logic [7:0] CMD_RUN   = 8'h52;
    localparam logic [7:0] CMD_STEP  = 8'h53;
    localparam logic [7:0] CMD_CLEAR = 8'h43;
    localparam logic [7:0] CMD_PAUSE = 8'h50;

    localparam logic [DATA_WIDTH-1:0] STEP_INC = DATA_WIDTH'(ADDR_STEP);

    logic [2:0]            state;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [8:0]            remaining;
    logic [1:0]            byte_idx;
    logic                  hold_valid;
    logic [7:0]            hold_data;
    logic                  wr_en_q;
    logic                  flush_q;
    logic [31:0]           count_q;

    logic                  byte_avail;
    logic [7:0]            byte_val;
    logic [31:0]           n_words;

    // A byte caught during LD_WRITE is parked in hold_data and takes priority
    // over the live strobe; a live byte arriving meanwhile replaces it.
    always_comb begin
        byte_avail = hold_valid | i_rx_valid;
        byte_val   = hold_valid ? hold_data : i_rx_data;
        n_words    = (i_rx_data == 8'd0) ? 32'd256 : {24'd0, i_rx_data};
        if (n_words > MEM_DEPTH) begin
            n_words = MEM_DEPTH;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state      <= S_IDLE;
            shift_q    <= '0;
            addr_q     <= '0;
            remaining  <= '0;
            byte_idx   <= '0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            wr_en_q    <= 1'b0;
            flush_q    <= 1'b0;
            count_q    <= '0;
        end else begin
            wr_en_q <= 1'b0;
            flush_q <= 1'b0;
            if (o_pipe_enable && (count_q != '1)) begin
                count_q <= count_q + 32'd1;
            end

            case (state)
                S_IDLE, S_HALTED: begin
                    if (i_rx_valid) begin
                        if (i_rx_data == CMD_LOAD) begin
                            state   <= S_LD_COUNT;
                            addr_q  <= '0;
                            count_q <= '0;
                        end else if (i_rx_data == CMD_CLEAR) begin
                            state   <= S_IDLE;
                            flush_q <= 1'b1;
                            count_q <= '0;
                        end else if (state == S_IDLE && i_rx_data == CMD_RUN) begin
                            state <= S_RUN;
                        end else if (state == S_IDLE && i_rx_data == CMD_STEP) begin
                            state <= S_STEP;
                        end
                    end
                end
                S_LD_COUNT: begin
                    if (i_rx_valid) begin
                        remaining <= n_words[8:0];
                        byte_idx  <= '0;
                        state     <= S_LD_BYTE;
                    end
                end
                S_LD_BYTE: begin
                    if (byte_avail) begin
                        shift_q  <= {shift_q[DATA_WIDTH-9:0], byte_val};
                        byte_idx <= byte_idx + 2'd1;
                        if (hold_valid) begin
                            hold_valid <= i_rx_valid;
                            hold_data  <= i_rx_data;
                        end
                        if (byte_idx == 2'd3) begin
                            wr_en_q <= 1'b1;
                            state   <= S_LD_WRITE;
                        end
                    end
                end
                S_LD_WRITE: begin
                    addr_q    <= addr_q + STEP_INC;
                    remaining <= remaining - 9'd1;
                    if (remaining == 9'd1) begin
                        flush_q    <= 1'b1;
                        hold_valid <= 1'b0;
                        state      <= S_IDLE;
                    end else begin
                        state <= S_LD_BYTE;
                        if (i_rx_valid) begin
                            hold_valid <= 1'b1;
                            hold_data  <= i_rx_data;
                        end
                    end
                end
                S_RUN: begin
                    if (i_halt) begin
                        state <= S_HALTED;
                    end else if (i_rx_valid && i_rx_data == CMD_PAUSE) begin
                        state <= S_IDLE;
                    end
                end
                S_STEP: begin
                    state <= i_halt ? S_HALTED : S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_instruccion = shift_q;
    assign o_address     = addr_q;
    assign o_wr_en       = wr_en_q;
    assign o_pipe_flush  = flush_q;
    assign o_cycle_count = count_q;
    assign o_loading     = (state == S_LD_COUNT) || (state == S_LD_BYTE) || (state == S_LD_WRITE);
    assign o_pipe_enable = (state == S_RUN) || (state == S_STEP);
    assign o_busy        = (state != S_IDLE) && (state != S_HALTED);
    assign o_halted      = (state == S_HALTED);

endmodule

// File: tb/tb_fetch_load_ctrl.sv
// Randomized self-checking bench for fetch_load_ctrl against a word-level
// model of loads and a cycle-count model of run/step/pause/halt.
module tb_fetch_load_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        halt;
    logic [31:0] instr, addr, cycle_count;
    logic        loading, wr_en, pipe_en, flush, busy, halted;

    always #5 clk = ~clk;

    fetch_load_ctrl #(.DATA_WIDTH(32), .ADDR_STEP(4), .MEM_DEPTH(256)) dut (
        .i_clock      (clk),
        .i_reset      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .i_halt       (halt),
        .o_instruccion(instr),
        .o_address    (addr),
        .o_loading    (loading),
        .o_wr_en      (wr_en),
        .o_pipe_enable(pipe_en),
        .o_pipe_flush (flush),
        .o_busy       (busy),
        .o_halted     (halted),
        .o_cycle_count(cycle_count)
    );

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    wr_t         wr_q[$];
    logic [7:0]  byte_q[$];
    int          flush_cnt = 0;
    int          en_cycles = 0;
    int          en_pulses = 0;
    bit          prev_en = 1'b0;
    bit          in_load = 1'b0;
    bit          load_dropped = 1'b0;
    bit          en_in_load = 1'b0;
    int unsigned exp_count = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (wr_en) wr_q.push_back('{instr, addr});
        if (flush) flush_cnt++;
        if (pipe_en) en_cycles++;
        if (pipe_en && !prev_en) en_pulses++;
        prev_en = pipe_en;
        if (in_load && !flush) begin
            if (!loading) load_dropped = 1'b1;
            if (pipe_en) en_in_load = 1'b1;
        end
    end

    // Called at a falling edge; the byte is sampled on the next rising edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic check_idle_state(input string tag);
        check_eq({tag, "_busy"},   64'(busy),        64'(0));
        check_eq({tag, "_enable"}, 64'(pipe_en),     64'(0));
        check_eq({tag, "_halted"}, 64'(halted),      64'(0));
        check_eq({tag, "_count"},  64'(cycle_count), 64'(exp_count));
    endtask

    task automatic do_load(input int n_field, input bit zero_gap_first);
        wr_t exp_q[$];
        int  nw;
        int  f0;
        int  t;
        bit  seen;
        nw = (n_field == 0) ? 256 : n_field;
        for (int i = 0; i < nw; i++) begin
            exp_q.push_back('{{byte_q[4*i], byte_q[4*i+1], byte_q[4*i+2], byte_q[4*i+3]}, 32'(i * 4)});
        end
        wr_q.delete();
        f0 = flush_cnt;
        load_dropped = 1'b0;
        en_in_load = 1'b0;
        send_byte(8'h4C, 0);
        in_load = 1'b1;
        exp_count = 0;
        check_eq("load_loading_rise", 64'(loading), 64'(1));
        send_byte(n_field[7:0], $urandom_range(0, 2));
        for (int w = 0; w < nw; w++) begin
            for (int k = 0; k < 4; k++) begin
                int gap;
                if (k < 3 || w == nw - 1) gap = 0;
                else if (w == 0 && zero_gap_first) gap = 0;
                else gap = $urandom_range(1, 3);
                send_byte(byte_q[4*w+k], gap);
            end
        end
        seen = 1'b0;
        t = 0;
        while (!seen && t < 100) begin
            if (flush) seen = 1'b1;
            else begin
                @(negedge clk);
                t++;
            end
        end
        in_load = 1'b0;
        check_eq("load_flush_timeout", 64'(seen), 64'(1));
        check_eq("load_flush_loading_low", 64'(loading), 64'(0));
        repeat (3) @(negedge clk);
        check_eq("load_flush_pulses", 64'(flush_cnt - f0), 64'(1));
        check_eq("load_wr_count", 64'(wr_q.size()), 64'(nw));
        for (int i = 0; i < nw && i < wr_q.size(); i++) begin
            check_eq($sformatf("wr_data[%0d]", i), 64'(wr_q[i].data), 64'(exp_q[i].data));
            check_eq($sformatf("wr_addr[%0d]", i), 64'(wr_q[i].addr), 64'(exp_q[i].addr));
        end
        check_eq("load_loading_gap", 64'(load_dropped), 64'(0));
        check_eq("load_enable_seen", 64'(en_in_load), 64'(0));
        check_idle_state("after_load");
    endtask

    task automatic run_halt(input int k);
        send_byte(8'h52, 0);
        check_eq("run_enable", 64'(pipe_en), 64'(1));
        check_eq("run_busy", 64'(busy), 64'(1));
        repeat (k - 1) @(negedge clk);
        halt = 1'b1;
        @(negedge clk);
        halt = 1'b0;
        exp_count += k;
        check_eq("halt_halted", 64'(halted), 64'(1));
        check_eq("halt_enable", 64'(pipe_en), 64'(0));
        check_eq("halt_busy", 64'(busy), 64'(0));
        check_eq("halt_count", 64'(cycle_count), 64'(exp_count));
    endtask

    task automatic clear_cmd();
        send_byte(8'h43, 0);
        exp_count = 0;
        check_eq("clear_flush", 64'(flush), 64'(1));
        check_idle_state("clear");
        @(negedge clk);
        check_eq("clear_flush_single", 64'(flush), 64'(0));
    endtask

    task automatic run_pause(input int k);
        send_byte(8'h52, 0);
        if (k >= 3) begin
            send_byte(8'h4C, 0);
            repeat (k - 2) @(negedge clk);
        end else begin
            repeat (k - 1) @(negedge clk);
        end
        send_byte(8'h50, 0);
        exp_count += k;
        check_idle_state("pause");
        check_eq("pause_loading", 64'(loading), 64'(0));
    endtask

    initial begin
        int n;
        int e0;
        int p0;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = '0;
        halt     = 1'b0;
        #1;
        check_eq("rst_instr", 64'(instr), 64'(0));
        check_eq("rst_addr", 64'(addr), 64'(0));
        check_eq("rst_strobes", 64'({loading, wr_en, pipe_en, flush, busy, halted}), 64'(0));
        check_eq("rst_count", 64'(cycle_count), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        byte_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h13};
        do_load(2, 1'b1);

        repeat (3) begin
            n = $urandom_range(1, 6);
            byte_q.delete();
            repeat (4 * n) byte_q.push_back(8'($urandom));
            byte_q[1] = 8'h52;
            byte_q[3] = 8'h53;
            do_load(n, ($urandom_range(0, 1) == 1));
        end

        run_halt(10);
        send_byte(8'h52, 2);
        send_byte(8'h53, 2);
        check_eq("halted_ignore_rs", 64'(halted), 64'(1));
        check_eq("halted_ignore_en", 64'(pipe_en), 64'(0));
        check_eq("halted_ignore_cnt", 64'(cycle_count), 64'(exp_count));
        clear_cmd();
        run_halt($urandom_range(1, 40));
        clear_cmd();

        e0 = en_cycles;
        p0 = en_pulses;
        repeat (3) begin
            send_byte(8'h53, 0);
            check_eq("step_enable_hi", 64'(pipe_en), 64'(1));
            @(negedge clk);
            check_eq("step_enable_lo", 64'(pipe_en), 64'(0));
            check_eq("step_busy", 64'(busy), 64'(0));
            repeat (3) @(negedge clk);
            exp_count += 1;
        end
        check_eq("step_en_cycles", 64'(en_cycles - e0), 64'(3));
        check_eq("step_en_pulses", 64'(en_pulses - p0), 64'(3));
        check_eq("step_count", 64'(cycle_count), 64'(exp_count));

        halt = 1'b1;
        send_byte(8'h53, 0);
        @(negedge clk);
        halt = 1'b0;
        exp_count += 1;
        check_eq("step_halt_halted", 64'(halted), 64'(1));
        check_eq("step_halt_count", 64'(cycle_count), 64'(exp_count));
        clear_cmd();

        run_pause(7);
        run_pause($urandom_range(1, 30));

        byte_q.delete();
        repeat (1024) byte_q.push_back(8'($urandom));
        do_load(0, 1'b0);
        check_eq("full_last_addr", 64'(wr_q[wr_q.size()-1].addr), 64'(32'h3FC));

        send_byte(8'h52, 0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midrun_rst_strobes", 64'({loading, wr_en, pipe_en, flush, busy, halted}), 64'(0));
        check_eq("midrun_rst_count", 64'(cycle_count), 64'(0));
        check_eq("midrun_rst_data", 64'({instr, addr}), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = 0;
        @(negedge clk);
        check_idle_state("after_rst");

        send_byte(8'h4C, 0);
        send_byte(8'h03, 0);
        send_byte(8'hAA, 0);
        check_eq("midload_loading", 64'(loading), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check_eq("midload_rst_loading", 64'(loading), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
